// File: rtl/ov2640_pixel_capture_if.sv
// ov2640_pixel_capture_if
//   Bundles the OV2640 DVP input bus and the assembled pixel stream.
//   Signals:
//     cam_vsync, cam_href, cam_d[7:0]       : raw camera side (driven by the camera / bench)
//     pixel_out[15:0], pixel_valid          : assembled pixel stream
//     VSYNC, frame_done, frame_err          : frame status toward downstream
//   Modports:
//     master : the camera/producer side (drives cam_*, observes results)
//     slave  : the capture block (reads cam_*, drives results)
//   Handshake: pixel_valid is a one-cycle strobe with no back-pressure. pixel_out
//   is meaningful only in a cycle where pixel_valid is 1, and the consumer must
//   take it in that cycle; there is no ready signal and no stalling.
interface ov2640_pixel_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_d;
  logic [15:0] pixel_out;
  logic        pixel_valid;
  logic        VSYNC;
  logic        frame_done;
  logic        frame_err;

  modport master (
    output cam_vsync, cam_href, cam_d,
    input  pixel_out, pixel_valid, VSYNC, frame_done, frame_err
  );

  modport slave (
    input  cam_vsync, cam_href, cam_d,
    output pixel_out, pixel_valid, VSYNC, frame_done, frame_err
  );
endinterface

// File: rtl/ov2640_pixel_capture.sv
// ov2640_pixel_capture
//   Front end of the camera pipeline. Samples the OV2640 8-bit DVP bus on PCLK,
//   pairs bytes into 16-bit pixels (first byte -> [15:8]), emits a pixel_valid
//   strobe and a registered active-frame VSYNC, and checks frame geometry.
//   Capture only begins on a clean blank->active boundary after reset.
//   Ports:
//     PCLK    : camera pixel clock, all logic on posedge
//     rst     : asynchronous active-high reset
//     bus     : ov2640_pixel_capture_if.slave (camera inputs, pixel/status outputs)
//     state_o : current FSM state (0=SYNC, 1=BLANK, 2=ACTIVE) for observation
module ov2640_pixel_capture #(
  parameter int CAM_WIDTH  = 640,
  parameter int CAM_HEIGHT = 480,
  parameter bit VSYNC_POL  = 1'b1
) (
  input  logic                         PCLK,
  input  logic                         rst,
  ov2640_pixel_capture_if.slave        bus,
  output logic [1:0]                   state_o
);

  localparam int PW = $clog2(CAM_WIDTH + 2);
  localparam int LW = $clog2(CAM_HEIGHT + 2);

  localparam logic [PW-1:0] PIX_FULL = PW'(CAM_WIDTH);
  localparam logic [PW-1:0] PIX_MAX  = PW'(CAM_WIDTH + 1);
  localparam logic [LW-1:0] LINE_FULL = LW'(CAM_HEIGHT);
  localparam logic [LW-1:0] LINE_MAX  = LW'(CAM_HEIGHT + 1);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [7:0]      hi_q, hi_d;
  logic            href_q, href_d;
  logic [15:0]     pix_q, pix_d;
  logic            pv_q, pv_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;

  logic vs_blank;
  assign vs_blank = (bus.cam_vsync == VSYNC_POL);

  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      state_q    <= SYNC;
      phase_q    <= 1'b0;
      hi_q       <= 8'h00;
      href_q     <= 1'b0;
      pix_q      <= 16'h0000;
      pv_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      href_q     <= href_d;
      pix_q      <= pix_d;
      pv_q       <= pv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    href_d     = 1'b0;
    pix_d      = pix_q;
    pv_d       = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;

    case (state_q)
      // Wait for a blanking interval so capture never starts mid-frame.
      SYNC: begin
        if (vs_blank) state_d = BLANK;
      end

      BLANK: begin
        if (!vs_blank) begin
          state_d    = ACTIVE;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
          err_d      = 1'b0;
          phase_d    = 1'b0;
        end
      end

      ACTIVE: begin
        href_d = bus.cam_href;

        // Bytes arriving together with vs_blank are not captured, so no
        // pixel_valid can land in a cycle where VSYNC is already low.
        if (bus.cam_href && !vs_blank) begin
          if (!phase_q) begin
            hi_d    = bus.cam_d;
            phase_d = 1'b1;
          end else begin
            pix_d   = {hi_q, bus.cam_d};
            pv_d    = 1'b1;
            phase_d = 1'b0;
            if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end else if (!bus.cam_href) begin
          phase_d = 1'b0;
          // href falling edge closes the line and checks its length.
          if (href_q) begin
            if (line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + 1'b1;
            if (phase_q || (pix_cnt_q != PIX_FULL)) err_d = 1'b1;
            pix_cnt_d = '0;
          end
        end

        // End-of-frame check uses the line count and error flag after any
        // line closed on this same edge.
        if (vs_blank) begin
          state_d = BLANK;
          href_d  = 1'b0;
          phase_d = 1'b0;
          if (bus.cam_href) begin
            err_d = 1'b1;
          end else if (line_cnt_d != LINE_FULL) begin
            err_d = 1'b1;
          end else if (!err_d) begin
            done_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  assign bus.pixel_out   = pix_q;
  assign bus.pixel_valid = pv_q;
  assign bus.VSYNC       = (state_q == ACTIVE);
  assign bus.frame_done  = done_q;
  assign bus.frame_err   = err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_ov2640_pixel_capture.sv
module tb_ov2640_pixel_capture;
  localparam int W = 4;
  localparam int H = 2;

  logic       PCLK;
  logic       rst;
  logic [1:0] state_o;

  ov2640_pixel_capture_if bus();

  ov2640_pixel_capture #(
    .CAM_WIDTH (W),
    .CAM_HEIGHT(H),
    .VSYNC_POL (1'b1)
  ) dut (
    .PCLK   (PCLK),
    .rst    (rst),
    .bus    (bus),
    .state_o(state_o)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          pv_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] first_pix = 16'h0000;
  logic [7:0]  nb = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge PCLK) begin
    #1;
    if (bus.pixel_valid === 1'b1) begin
      if (pv_cnt == 0) first_pix = bus.pixel_out;
      pv_cnt++;
      chk("pv_in_frame", {31'd0, bus.VSYNC}, 32'd1);
      if (exp_q.size() == 0) chk("pv_unexpected", 32'd1, 32'd0);
      else chk("pixel", {16'd0, bus.pixel_out}, {16'd0, exp_q.pop_front()});
    end
    if (bus.frame_done === 1'b1) done_cnt++;
  end

  // driver tasks
  task automatic cyc(input logic vs, input logic href, input logic [7:0] d);
    @(negedge PCLK);
    bus.cam_vsync = vs;
    bus.cam_href  = href;
    bus.cam_d     = d;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic active_idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int nbytes, input bit push);
    logic [7:0] prev;
    prev = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      nb = nb + 8'h10;
      cyc(1'b0, 1'b1, nb);
      if (i[0] && push) exp_q.push_back({prev, nb});
      prev = nb;
    end
  endtask

  task automatic run_frame(input int nlines, input int nbytes);
    blank(4);
    active_idle(2);
    for (int l = 0; l < nlines; l++) begin
      send_line(nbytes, 1'b1);
      active_idle(2);
    end
    blank(4);
  endtask

  task automatic settle;
    @(posedge PCLK);
    #2;
  endtask

  int pv0, dn0;

  initial begin
    rst = 1'b1;
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_d     = 8'h00;
    repeat (2) settle();

    // reset state
    chk("rst_pixel_out", {16'd0, bus.pixel_out}, 32'h0);
    chk("rst_pixel_valid", {31'd0, bus.pixel_valid}, 32'd0);
    chk("rst_vsync", {31'd0, bus.VSYNC}, 32'd0);
    chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);

    // 1: basic 2x4 frame
    @(negedge PCLK);
    rst = 1'b0;
    bus.cam_vsync = 1'b1;
    pv0 = pv_cnt; dn0 = done_cnt;
    run_frame(2, 8);
    settle();
    chk("t1_pv_count", pv_cnt - pv0, 32'd8);
    chk("t1_first_pix", {16'd0, first_pix}, 32'h1020);
    chk("t1_done", done_cnt - dn0, 32'd1);
    chk("t1_err", {31'd0, bus.frame_err}, 32'd0);
    chk("t1_state_blank", {30'd0, state_o}, 32'd1);

    // 2: reset released mid-frame
    rst = 1'b1;
    pv0 = pv_cnt; dn0 = done_cnt;
    send_line(4, 1'b0);
    @(negedge PCLK);
    rst = 1'b0;
    send_line(6, 1'b0);
    active_idle(1);
    send_line(4, 1'b0);
    active_idle(2);
    settle();
    chk("t2_vsync_low", {31'd0, bus.VSYNC}, 32'd0);
    chk("t2_state_sync", {30'd0, state_o}, 32'd0);
    chk("t2_no_pv", pv_cnt - pv0, 32'd0);
    blank(2);
    settle();
    chk("t2_state_blank", {30'd0, state_o}, 32'd1);
    chk("t2_vsync_blank", {31'd0, bus.VSYNC}, 32'd0);
    run_frame(2, 8);
    settle();
    chk("t2_pv_count", pv_cnt - pv0, 32'd8);
    chk("t2_done", done_cnt - dn0, 32'd1);
    chk("t2_err", {31'd0, bus.frame_err}, 32'd0);

    // 3: odd-length line
    pv0 = pv_cnt; dn0 = done_cnt;
    blank(4);
    active_idle(2);
    send_line(7, 1'b1);
    active_idle(1);
    settle();
    chk("t3_err_at_fall", {31'd0, bus.frame_err}, 32'd1);
    active_idle(1);
    send_line(8, 1'b1);
    active_idle(2);
    blank(4);
    settle();
    chk("t3_pv_count", pv_cnt - pv0, 32'd7);
    chk("t3_no_done", done_cnt - dn0, 32'd0);
    chk("t3_err_sticky", {31'd0, bus.frame_err}, 32'd1);

    // 4: short frame, then a good one
    pv0 = pv_cnt; dn0 = done_cnt;
    blank(4);
    active_idle(2);
    send_line(8, 1'b1);
    active_idle(2);
    settle();
    chk("t4_err_cleared", {31'd0, bus.frame_err}, 32'd0);
    chk("t4_vsync_active", {31'd0, bus.VSYNC}, 32'd1);
    blank(4);
    settle();
    chk("t4_err_short", {31'd0, bus.frame_err}, 32'd1);
    chk("t4_no_done", done_cnt - dn0, 32'd0);
    run_frame(2, 8);
    settle();
    chk("t4_good_done", done_cnt - dn0, 32'd1);
    chk("t4_good_err", {31'd0, bus.frame_err}, 32'd0);
    chk("t4_pv_count", pv_cnt - pv0, 32'd12);

    // 5: href fall on the same edge as vsync blank
    dn0 = done_cnt;
    blank(4);
    active_idle(2);
    send_line(8, 1'b1);
    active_idle(2);
    send_line(8, 1'b1);
    settle();
    chk("t5_vsync_before", {31'd0, bus.VSYNC}, 32'd1);
    cyc(1'b1, 1'b0, 8'h00);
    settle();
    chk("t5_vsync_dropped", {31'd0, bus.VSYNC}, 32'd0);
    chk("t5_frame_done", {31'd0, bus.frame_done}, 32'd1);
    chk("t5_err", {31'd0, bus.frame_err}, 32'd0);
    blank(2);
    settle();
    chk("t5_done_once", done_cnt - dn0, 32'd1);

    // 6: reset while pixel_valid is high
    blank(2);
    active_idle(2);
    send_line(2, 1'b1);
    @(posedge PCLK);
    #2;
    chk("t6_pv_high", {31'd0, bus.pixel_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_pv_cleared", {31'd0, bus.pixel_valid}, 32'd0);
    chk("t6_pix_cleared", {16'd0, bus.pixel_out}, 32'h0);
    chk("t6_vsync_cleared", {31'd0, bus.VSYNC}, 32'd0);
    chk("t6_state_sync", {30'd0, state_o}, 32'd0);
    active_idle(1);
    @(negedge PCLK);
    rst = 1'b0;
    active_idle(3);
    settle();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
